uart_tx: RTL and testbench

Standalone RS-232 transmitter that frames and serialises bytes from a parallel valid/ready source onto `txd_out`. It has a programmable bit period, optional parity, one or two stop bits, and a small input FIFO so a producer can queue bytes back-to-back. It is the host-side transmit end of the same 8N1-style serial link our echo port receives on. It is also the first piece of a split receiver/transmitter pair that replaces the combined loopback block.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_fifo.sv | 57 +++++
 rtl/uart_tx.sv | 148 ++++++++++++++
 tb/tb_uart_tx.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit/receive pair: FSM states, frame constants
// and the parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_e;

  localparam logic        START_BIT = 1'b0;
  localparam logic        STOP_BIT  = 1'b1;
  localparam int unsigned DATA_BITS = 8;

  // Even parity when odd = 0, odd parity when odd = 1.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with full/empty flags; pointers carry one extra wrap bit so that
// full and empty are distinguishable when the address bits match.
module uart_fifo
  import uart_pkg::*;
#(
  parameter int unsigned Width = DATA_BITS,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [Width-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [Width-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW:0]   wr_ptr_q, wr_ptr_d;
  logic [AddrW:0]   rd_ptr_q, rd_ptr_d;
  logic             wr_fire, rd_fire;

  assign full_o  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                   (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);

  assign wr_fire = wr_en_i && !full_o;
  assign rd_fire = rd_en_i && !empty_o;

  assign rd_data_o = mem_q[rd_ptr_q[AddrW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_fire) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_fire) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk_i) begin
    if (wr_fire) mem_q[wr_ptr_q[AddrW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/uart_tx.sv
// RS-232 transmitter: queues bytes in a small FIFO and serialises them as
// start / 8 data (LSB first) / optional parity / 1-2 stop bits on a registered line.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 valid_in,
  output logic                 ready_out,
  output logic                 txd_out,
  output logic                 busy_out
);

  localparam int unsigned TimerW = $clog2(CLK_DIV);
  typedef logic [TimerW-1:0] timer_t;
  localparam timer_t     TimerLoad = timer_t'(CLK_DIV - 1);
  localparam logic [2:0] LastData  = 3'(DATA_BITS - 1);
  localparam logic [2:0] LastStop  = 3'(STOP_BITS - 1);

  tx_state_e              state_q;
  timer_t                 timer_q;
  logic [2:0]             idx_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic                   par_q;
  logic                   txd_q;

  logic [DATA_BITS-1:0]   fifo_rd_data;
  logic                   fifo_full, fifo_empty;
  logic                   bit_end, last_stop, pop;

  assign bit_end   = (timer_q == '0);
  assign last_stop = (idx_q == LastStop);

  // Pop on leaving idle, or at the end of the final stop bit for a gapless next frame.
  always_comb begin
    pop = 1'b0;
    if (!fifo_empty) begin
      if (state_q == StIdle) pop = 1'b1;
      if (state_q == StStop && bit_end && last_stop) pop = 1'b1;
    end
  end

  uart_fifo #(
    .Width (DATA_BITS),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk_in),
    .rst_i     (rst_in),
    .wr_en_i   (valid_in),
    .wr_data_i (data_in),
    .rd_en_i   (pop),
    .rd_data_o (fifo_rd_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= StIdle;
      timer_q <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      txd_q   <= STOP_BIT;
    end else begin
      if (pop) begin
        shift_q <= fifo_rd_data;
        par_q   <= parity_bit(fifo_rd_data, PARITY_ODD != 0);
      end
      // The line lags the state by one cycle, uniformly, so every bit keeps its width.
      unique case (state_q)
        StIdle: begin
          txd_q <= STOP_BIT;
          if (pop) begin
            state_q <= StStart;
            timer_q <= TimerLoad;
            idx_q   <= '0;
          end
        end
        StStart: begin
          txd_q <= START_BIT;
          if (bit_end) begin
            state_q <= StData;
            timer_q <= TimerLoad;
            idx_q   <= '0;
          end else begin
            timer_q <= timer_q - timer_t'(1);
          end
        end
        StData: begin
          txd_q <= shift_q[0];
          if (bit_end) begin
            timer_q <= TimerLoad;
            shift_q <= shift_q >> 1;
            if (idx_q == LastData) begin
              idx_q   <= '0;
              state_q <= (PARITY_EN != 0) ? StParity : StStop;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end else begin
            timer_q <= timer_q - timer_t'(1);
          end
        end
        StParity: begin
          txd_q <= par_q;
          if (bit_end) begin
            state_q <= StStop;
            timer_q <= TimerLoad;
            idx_q   <= '0;
          end else begin
            timer_q <= timer_q - timer_t'(1);
          end
        end
        StStop: begin
          txd_q <= STOP_BIT;
          if (bit_end) begin
            timer_q <= TimerLoad;
            if (last_stop) begin
              idx_q   <= '0;
              state_q <= pop ? StStart : StIdle;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end else begin
            timer_q <= timer_q - timer_t'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          txd_q   <= STOP_BIT;
        end
      endcase
    end
  end

  assign ready_out = !fifo_full;
  assign busy_out  = (state_q != StIdle) || !fifo_empty;
  assign txd_out   = txd_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four instances cover 8N1, even/odd parity and two stop bits,
// with a negedge line log used to check whole frames bit by bit.
module tb_uart_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] a_data, po_data, s_data;
  logic       a_valid, po_valid, s_valid;
  logic       a_ready, a_txd, a_busy;
  logic       p_ready, p_txd, p_busy;
  logic       o_ready, o_txd, o_busy;
  logic       s_ready, s_txd, s_busy;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [3:0] log_q [0:2047];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (cyc < 2048) log_q[cyc] = {s_txd, o_txd, p_txd, a_txd};

  uart_tx #(.CLK_DIV(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
    .clk_in(clk), .rst_in(rst), .data_in(a_data), .valid_in(a_valid),
    .ready_out(a_ready), .txd_out(a_txd), .busy_out(a_busy));

  uart_tx #(.CLK_DIV(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_p (
    .clk_in(clk), .rst_in(rst), .data_in(po_data), .valid_in(po_valid),
    .ready_out(p_ready), .txd_out(p_txd), .busy_out(p_busy));

  uart_tx #(.CLK_DIV(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_o (
    .clk_in(clk), .rst_in(rst), .data_in(po_data), .valid_in(po_valid),
    .ready_out(o_ready), .txd_out(o_txd), .busy_out(o_busy));

  uart_tx #(.CLK_DIV(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_s (
    .clk_in(clk), .rst_in(rst), .data_in(s_data), .valid_in(s_valid),
    .ready_out(s_ready), .txd_out(s_txd), .busy_out(s_busy));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // par < 0 means no parity bit; every bit must hold its level for all 4 cycles.
  task automatic chk_frame(input string tag, input int lane, input int t0, input logic [7:0] b,
                           input int par, input int nstop);
    logic [11:0] bits;
    logic [3:0]  s;
    int          n;
    bits = '0;
    n = 1;
    for (int i = 0; i < 8; i++) begin
      bits[n] = b[i];
      n++;
    end
    if (par >= 0) begin
      bits[n] = par[0];
      n++;
    end
    for (int i = 0; i < nstop; i++) begin
      bits[n] = 1'b1;
      n++;
    end
    chk($sformatf("%s pre", tag), 32'(log_q[t0-1][lane]), 32'd1);
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < 4; j++) s[j] = log_q[t0 + 4*k + j][lane];
      chk($sformatf("%s bit%0d", tag, k), 32'(s), 32'({4{bits[k]}}));
    end
  endtask

  initial begin
    int t, tb0, idx, budget, ones, zeros;
    logic acc;

    rst = 1'b1;
    a_data = '0; po_data = '0; s_data = '0;
    a_valid = 1'b0; po_valid = 1'b0; s_valid = 1'b0;
    repeat (3) tick();
    chk("reset txd", 32'({s_txd, o_txd, p_txd, a_txd}), 32'hF);
    chk("reset ready", 32'({s_ready, o_ready, p_ready, a_ready}), 32'hF);
    chk("reset busy", 32'({s_busy, o_busy, p_busy, a_busy}), 32'h0);
    #2 rst = 1'b0;
    tick();

    // Single byte 0x55, 8N1.
    a_data = 8'h55; a_valid = 1'b1;
    tick(); t = cyc; a_valid = 1'b0;
    chk("single busy N", 32'(a_busy), 32'd1);
    chk("single txd N", 32'(a_txd), 32'd1);
    tick();
    chk("single txd N+1", 32'(a_txd), 32'd1);
    tick();
    chk("single txd N+2", 32'(a_txd), 32'd0);
    wait_cyc(t + 40);
    chk("single busy N+40", 32'(a_busy), 32'd1);
    tick();
    chk("single busy N+41", 32'(a_busy), 32'd0);
    wait_cyc(t + 44);
    chk_frame("single", 0, t + 2, 8'h55, -1, 1);

    // Parity: 0x07 -> even parity 1, odd parity 0.
    po_data = 8'h07; po_valid = 1'b1;
    tick(); t = cyc; po_valid = 1'b0;
    wait_cyc(t + 47);
    chk_frame("par_even", 1, t + 2, 8'h07, 1, 1);
    chk_frame("par_odd", 2, t + 2, 8'h07, 0, 1);
    chk("parity busy end", 32'({o_busy, p_busy}), 32'h0);

    // Burst of six bytes with valid held high.
    idx = 0; tb0 = -1; budget = 0;
    a_valid = 1'b1;
    while (idx < 6 && budget < 200) begin
      a_data = 8'(8'hA0 + idx);
      acc = a_ready;
      tick();
      budget++;
      if (acc) begin
        if (idx == 0) tb0 = cyc;
        idx++;
        if (idx == 4) chk("burst ready after 4", 32'(a_ready), 32'd1);
        if (idx == 5) chk("burst ready full", 32'(a_ready), 32'd0);
      end
    end
    a_valid = 1'b0;
    chk("burst accepted", 32'(idx), 32'd6);
    if (tb0 < 0) tb0 = cyc;
    wait_cyc(tb0 + 243);
    for (int k = 0; k < 6; k++)
      chk_frame($sformatf("burst%0d", k), 0, tb0 + 2 + 40*k, 8'(8'hA0 + k), -1, 1);
    chk("burst busy end", 32'(a_busy), 32'd0);

    // Two stop bits: 0xFF then 0x00.
    s_data = 8'hFF; s_valid = 1'b1;
    tick(); t = cyc;
    s_data = 8'h00;
    tick();
    s_valid = 1'b0;
    wait_cyc(t + 91);
    chk_frame("stop2_ff", 3, t + 2, 8'hFF, -1, 2);
    chk_frame("stop2_00", 3, t + 46, 8'h00, -1, 2);
    ones = 0;
    for (int i = t + 6; i < t + 46; i++) if (log_q[i][3] === 1'b1) ones++;
    chk("stop2 high run", 32'(ones), 32'd40);

    // Mid-frame reset during data bit 3 of 0x00, with two more bytes queued.
    a_data = 8'h00; a_valid = 1'b1;
    tick(); t = cyc;
    a_data = 8'h33;
    tick();
    a_data = 8'h44;
    tick();
    a_valid = 1'b0;
    wait_cyc(t + 19);
    chk("pre-reset bit3", 32'(a_txd), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("async reset txd", 32'(a_txd), 32'd1);
    chk("async reset ready", 32'(a_ready), 32'd1);
    chk("async reset busy", 32'(a_busy), 32'd0);
    tick();
    tick();
    #2 rst = 1'b0;
    t = cyc;
    wait_cyc(t + 60);
    zeros = 0;
    for (int i = t; i < t + 60; i++) if (log_q[i][0] !== 1'b1) zeros++;
    chk("fifo discarded", 32'(zeros), 32'd0);
    chk("post-reset busy", 32'(a_busy), 32'd0);
    a_data = 8'h5A; a_valid = 1'b1;
    tick(); t = cyc; a_valid = 1'b0;
    wait_cyc(t + 46);
    chk_frame("after_reset", 0, t + 2, 8'h5A, -1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
